// File: rtl/hd32_issue_queue.sv
// hd32_issue_queue: request front end for the combinational HD32 divider.
// Requests are buffered in a circular FIFO, issued one per cycle from an
// issue register (p1) into the divider, and the divider outputs are captured
// with the request tag into a result register (p2) that is drained over a
// valid/ready handshake. Results always leave in acceptance order.
module hd32_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [31:0]              in_dividend,
  input  logic [31:0]              in_divider,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     div_mode,
  output logic [31:0]              div_dividend,
  output logic [31:0]              div_divider,
  input  logic [31:0]              div_quotient,
  input  logic [31:0]              div_remainder,
  input  logic                     div_zero_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_quotient,
  output logic [31:0]              out_remainder,
  output logic                     out_zero_error,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         zero_err_cnt
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int REQ_W  = 1 + 2 * DATA_W + TAG_W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Request storage and pointers.
  logic [REQ_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // FIFO head fields.
  logic              head_mode;
  logic [DATA_W-1:0] head_dividend;
  logic [DATA_W-1:0] head_divider;
  logic [TAG_W-1:0]  head_tag;

  // Issue stage registers.
  logic              vld_p1;
  logic              iss_mode_p1;
  logic [DATA_W-1:0] iss_dividend_p1;
  logic [DATA_W-1:0] iss_divider_p1;
  logic [TAG_W-1:0]  iss_tag_p1;

  // Result stage registers.
  logic              vld_p2;
  logic [DATA_W-1:0] res_quotient_p2;
  logic [DATA_W-1:0] res_remainder_p2;
  logic              res_zero_error_p2;
  logic [TAG_W-1:0]  res_tag_p2;

  // Handshake / flow-control terms.
  logic push;
  logic pop;
  logic adv;
  logic out_fire;

  // in_ready drops during reset and whenever the FIFO is full; a full FIFO
  // never accepts a push even if it pops in the same cycle.
  assign in_ready = !rst && (fifo_count < FULL_CNT);
  assign push     = in_valid && in_ready;
  assign out_fire = vld_p2 && out_ready;
  assign adv      = vld_p1 && (!vld_p2 || out_ready);
  assign pop      = (fifo_count != '0) && (!vld_p1 || adv);

  assign {head_mode, head_dividend, head_divider, head_tag} = mem[rd_ptr];

  // ---- p0: request FIFO ----

  // Write the accepted request into the slot under the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_mode, in_dividend, in_divider, in_tag};
    end
  end

  // Pointers wrap modulo DEPTH; occupancy is unchanged on push+pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        fifo_count <= fifo_count + (AW + 1)'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - (AW + 1)'(1);
      end
    end
  end

  // ---- p1: issue register, feeds the divider directly ----

  // Load the FIFO head when the issue slot is free or draining; otherwise
  // just clear the valid bit when the current request moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1          <= 1'b0;
      iss_mode_p1     <= 1'b0;
      iss_dividend_p1 <= '0;
      iss_divider_p1  <= '0;
      iss_tag_p1      <= '0;
    end else if (pop) begin
      vld_p1          <= 1'b1;
      iss_mode_p1     <= head_mode;
      iss_dividend_p1 <= head_dividend;
      iss_divider_p1  <= head_divider;
      iss_tag_p1      <= head_tag;
    end else if (adv) begin
      vld_p1          <= 1'b0;
    end
  end

  assign div_mode     = iss_mode_p1;
  assign div_dividend = iss_dividend_p1;
  assign div_divider  = iss_divider_p1;

  // ---- p2: result register ----

  // Capture divider outputs with the issue tag on advance; a consumed result
  // with nothing behind it only drops valid, the data is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2            <= 1'b0;
      res_quotient_p2   <= '0;
      res_remainder_p2  <= '0;
      res_zero_error_p2 <= 1'b0;
      res_tag_p2        <= '0;
    end else if (adv) begin
      vld_p2            <= 1'b1;
      res_quotient_p2   <= div_quotient;
      res_remainder_p2  <= div_remainder;
      res_zero_error_p2 <= div_zero_error;
      res_tag_p2        <= iss_tag_p1;
    end else if (out_fire) begin
      vld_p2            <= 1'b0;
    end
  end

  assign out_valid      = vld_p2;
  assign out_quotient   = res_quotient_p2;
  assign out_remainder  = res_remainder_p2;
  assign out_zero_error = res_zero_error_p2;
  assign out_tag        = res_tag_p2;

  // Count delivered divide-by-zero results, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_err_cnt <= '0;
    end else if (out_fire && res_zero_error_p2) begin
      zero_err_cnt <= sat_inc(zero_err_cnt);
    end
  end

endmodule

// File: tb/tb_hd32_issue_queue.sv
// Testbench for hd32_issue_queue: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the request stream.
module tb_hd32_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CNT_W = 4;
  localparam int AW    = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [31:0]       in_dividend;
  logic [31:0]       in_divider;
  logic [TAG_W-1:0]  in_tag;
  logic              div_mode;
  logic [31:0]       div_dividend;
  logic [31:0]       div_divider;
  logic [31:0]       div_quotient;
  logic [31:0]       div_remainder;
  logic              div_zero_error;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_quotient;
  logic [31:0]       out_remainder;
  logic              out_zero_error;
  logic [TAG_W-1:0]  out_tag;
  logic [AW:0]       fifo_count;
  logic [CNT_W-1:0]  zero_err_cnt;

  int checks = 0;
  int errors = 0;

  hd32_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_dividend(in_dividend), .in_divider(in_divider), .in_tag(in_tag),
    .div_mode(div_mode), .div_dividend(div_dividend), .div_divider(div_divider),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_zero_error(div_zero_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_zero_error(out_zero_error), .out_tag(out_tag),
    .fifo_count(fifo_count), .zero_err_cnt(zero_err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural divider: {zero_error, quotient, remainder}.
  function automatic logic [64:0] div_ref(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; e = 1'b1;
    end else if (!m) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {e, q, r};
  endfunction

  always_comb begin
    {div_zero_error, div_quotient, div_remainder} = div_ref(div_mode, div_dividend, div_divider);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: outstanding results in acceptance order, and the
  // expected saturating zero-error count.
  typedef struct {
    logic [31:0]      q;
    logic [31:0]      r;
    logic             e;
    logic [TAG_W-1:0] t;
  } res_t;

  res_t exp_q[$];
  int   delivered = 0;
  int   zc_model  = 0;
  logic have_prev = 1'b0;
  logic [96:0] prev_out;

  // Monitor: inputs and outputs are stable at the falling edge, so the
  // handshakes seen here are the ones that complete at the next rising edge.
  always @(negedge clk) begin
    res_t e;
    logic [64:0] d;
    if (rst) begin
      exp_q.delete();
      zc_model  = 0;
      have_prev = 1'b0;
    end else begin
      chk("zero_err_cnt", 64'(zero_err_cnt), 64'(zc_model));
      if (have_prev) begin
        chk("stall_stable", 64'(prev_out == {out_valid, out_quotient, out_remainder, out_zero_error, out_tag}), 64'd1);
      end
      have_prev = out_valid && !out_ready;
      prev_out  = {out_valid, out_quotient, out_remainder, out_zero_error, out_tag};
      if (out_valid && out_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_tag", 64'(out_tag), 64'(e.t));
          chk("out_quotient", 64'(out_quotient), 64'(e.q));
          chk("out_remainder", 64'(out_remainder), 64'(e.r));
          chk("out_zero_error", 64'(out_zero_error), 64'(e.e));
          if (e.e && zc_model < (1 << CNT_W) - 1) zc_model++;
        end
      end
      if (in_valid && in_ready) begin
        d = div_ref(in_mode, in_dividend, in_divider);
        e.e = d[64];
        e.q = d[63:32];
        e.r = d[31:0];
        e.t = in_tag;
        exp_q.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    in_valid    = 1'b1;
    in_mode     = m;
    in_dividend = a;
    in_divider  = b;
    in_tag      = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int d0;
    int bad;
    int cycles;
    int tag;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_dividend = '0;
    in_divider = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) cyc();

    // Reset state (rst still high).
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_zero_err_cnt", 64'(zero_err_cnt), 64'd0);
    chk("rst_div_dividend", 64'(div_dividend), 64'd0);
    chk("rst_out_quotient", 64'(out_quotient), 64'd0);
    cyc();
    rst = 1'b0;

    // 1: unsigned 100/7, latency from acceptance to out_valid.
    out_ready = 1'b1;
    drive(1'b0, 32'd100, 32'd7, 5'd3);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_k", 64'(out_valid), 64'd0);
    cyc();
    @(negedge clk);
    chk("t1_valid_k1", 64'(out_valid), 64'd0);
    cyc();
    @(negedge clk);
    chk("t1_valid_k2", 64'(out_valid), 64'd1);
    chk("t1_q", 64'(out_quotient), 64'd14);
    chk("t1_r", 64'(out_remainder), 64'd2);
    chk("t1_err", 64'(out_zero_error), 64'd0);
    chk("t1_tag", 64'(out_tag), 64'd3);
    cyc();

    // 2: signed -7/2.
    drive(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5);
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_q", 64'(out_quotient), 64'hFFFF_FFFD);
    chk("t2_r", 64'(out_remainder), 64'hFFFF_FFFF);
    chk("t2_err", 64'(out_zero_error), 64'd0);
    cyc();
    cyc();

    // 3: stall with out_ready=0, fill to capacity, then drain.
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'd1000 + 32'(i * 37), 32'd3 + 32'(i), 5'(8 + accepted));
      @(negedge clk);
      acc = in_ready;
      cyc();
      if (acc) accepted++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_accepted", 64'(accepted), 64'd6);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_fifo_count", 64'(fifo_count), 64'd4);
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    cyc();
    out_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_consecutive", 64'(out_valid), 64'd1);
      cyc();
    end
    chk("t3_delivered", 64'(delivered - d0), 64'd6);
    @(negedge clk);
    chk("t3_drained", 64'(out_valid), 64'd0);
    cyc();

    // 4: divide by zero and counter saturation.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b0, 32'd5, 32'd0, 5'd7);
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_err", 64'(out_zero_error), 64'd1);
    chk("t4_q", 64'(out_quotient), 64'd0);
    chk("t4_r", 64'(out_remainder), 64'd0);
    chk("t4_cnt_before", 64'(zero_err_cnt), 64'd0);
    cyc();
    @(negedge clk);
    chk("t4_cnt_after", 64'(zero_err_cnt), 64'd1);
    cyc();
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 32'd0, 5'(i));
      cyc();
    end
    in_valid = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    chk("t4_saturated", 64'(zero_err_cnt), 64'((1 << CNT_W) - 1));
    cyc();

    // 5: reset with requests in flight discards them.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd50 + 32'(i), 32'd3, 5'(20 + i));
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_fifo_count", 64'(fifo_count), 64'd0);
    cyc();
    out_ready = 1'b1;
    d0  = delivered;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
      cyc();
    end
    chk("t5_no_stale", 64'(bad), 64'd0);
    chk("t5_delivered", 64'(delivered - d0), 64'd0);

    // 6: randomized traffic, tags 0..19 in order, random back-pressure.
    d0     = delivered;
    tag    = 0;
    cycles = 0;
    while (tag < 20 && cycles < 500) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_mode     = 1'($urandom_range(0, 1));
      in_dividend = $urandom;
      in_divider  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                    (($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      in_tag      = 5'(tag);
      out_ready   = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      cyc();
      if (acc) tag++;
      cycles++;
    end
    in_valid = 1'b0;
    chk("t6_accepted", 64'(tag), 64'd20);
    out_ready = 1'b1;
    cycles = 0;
    while ((delivered - d0) < 20 && cycles < 50) begin
      cyc();
      cycles++;
    end
    chk("t6_delivered", 64'(delivered - d0), 64'd20);
    chk("t6_model_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
